// File: rtl/bram_result_checker.sv
// rtl/bram_result_checker.sv - Checks C memory against A op B memories word by word.
// Optional first-mismatch capture is enabled by defining CHECKER_ERRLOG_EN.
module bram_result_checker #(
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 8,
    parameter int ADDR_W   = 3,
    parameter int ONE_SHOT = 0
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              start,
    input  logic              op_sel,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] a_rdata,
    input  logic [DATA_W-1:0] b_rdata,
    input  logic [DATA_W-1:0] c_rdata,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ADDR_W:0]   match_cnt,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [DATA_W-1:0] fail_data
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   FULL_CNT  = (ADDR_W + 1)'(DEPTH);

    state_t              state;
    state_t              state_nxt;
    logic                start_q;
    logic                ran_q;
    logic                op_q;
    logic                cmp_vld;
    logic                accept;
    logic                match;
    logic [ADDR_W-1:0]   addr_q;
    logic [ADDR_W:0]     match_nxt;
    logic [DATA_W-1:0]   expect_data;

    // A held-high start never looks like an edge because start_q tracks it every cycle.
    assign accept = (state == IDLE) && start && !start_q && !((ONE_SHOT != 0) && ran_q);

    assign expect_data = op_q ? (a_rdata - b_rdata) : (a_rdata + b_rdata);
    assign match       = cmp_vld && (c_rdata == expect_data);
    assign match_nxt   = match_cnt + {{ADDR_W{1'b0}}, match};
    assign rd_addr     = addr_q;

    always_ff @(posedge sys_clk) begin
        if (!sys_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        rd_en     = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (accept) begin
                    state_nxt = READ;
                end
            end
            READ: begin
                rd_en = 1'b1;
                if (addr_q == LAST_ADDR) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Read data lags rd_en by one cycle, so cmp_vld marks the cycle a compare is due.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst) begin
            start_q   <= 1'b0;
            ran_q     <= 1'b0;
            op_q      <= 1'b0;
            addr_q    <= '0;
            cmp_vld   <= 1'b0;
            match_cnt <= '0;
            pass      <= 1'b0;
        end else begin
            start_q <= start;
            cmp_vld <= rd_en;
            if (accept) begin
                op_q      <= op_sel;
                addr_q    <= '0;
                match_cnt <= '0;
                pass      <= 1'b0;
            end else begin
                match_cnt <= match_nxt;
                if (state == READ) begin
                    addr_q <= (addr_q == LAST_ADDR) ? '0 : addr_q + 1'b1;
                end
                // Include the final DRAIN compare so pass is already valid in DONE.
                if (state == DRAIN) begin
                    pass <= (match_nxt == FULL_CNT);
                end
                if (state == DONE) begin
                    ran_q <= 1'b1;
                end
            end
        end
    end

`ifdef CHECKER_ERRLOG_EN
    logic [ADDR_W-1:0] cmp_addr;
    logic [ADDR_W-1:0] fail_addr_q;
    logic [DATA_W-1:0] fail_data_q;
    logic              fail_seen;

    always_ff @(posedge sys_clk) begin
        if (!sys_rst) begin
            cmp_addr    <= '0;
            fail_addr_q <= '0;
            fail_data_q <= '0;
            fail_seen   <= 1'b0;
        end else begin
            cmp_addr <= addr_q;
            if (accept) begin
                fail_addr_q <= '0;
                fail_data_q <= '0;
                fail_seen   <= 1'b0;
            end else if (cmp_vld && !match && !fail_seen) begin
                fail_addr_q <= cmp_addr;
                fail_data_q <= c_rdata;
                fail_seen   <= 1'b1;
            end
        end
    end

    assign fail_addr = fail_addr_q;
    assign fail_data = fail_data_q;
`else
    assign fail_addr = '0;
    assign fail_data = '0;
`endif

endmodule

// File: tb/tb_bram_result_checker.sv
// tb/tb_bram_result_checker.sv - Self-checking bench for bram_result_checker.
module tb_bram_result_checker;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 8;
    localparam int ADDR_W = 3;
    localparam int DEPTH1 = 6;
`ifdef CHECKER_ERRLOG_EN
    localparam bit ERRLOG = 1'b1;
`else
    localparam bit ERRLOG = 1'b0;
`endif

    logic sys_clk = 1'b0;
    logic sys_rst = 1'b0;
    logic start   = 1'b0;
    logic op_sel  = 1'b0;

    logic              rd_en, busy, done, pass;
    logic [ADDR_W-1:0] rd_addr, fail_addr;
    logic [ADDR_W:0]   match_cnt;
    logic [DATA_W-1:0] a_rdata, b_rdata, c_rdata, fail_data;

    logic              rd_en1, busy1, done1, pass1;
    logic [ADDR_W-1:0] rd_addr1, fail_addr1;
    logic [ADDR_W:0]   match_cnt1;
    logic [DATA_W-1:0] a_rdata1, b_rdata1, c_rdata1, fail_data1;

    logic [DATA_W-1:0] mem_a [DEPTH];
    logic [DATA_W-1:0] mem_b [DEPTH];
    logic [DATA_W-1:0] mem_c [DEPTH];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_cnt = 0;
    int done1_cnt = 0;
    int busy1_cycles = 0;
    int lat, d0, b0, guard;

    bram_result_checker #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .ONE_SHOT(0)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .start(start), .op_sel(op_sel),
        .rd_en(rd_en), .rd_addr(rd_addr), .a_rdata(a_rdata), .b_rdata(b_rdata), .c_rdata(c_rdata),
        .busy(busy), .done(done), .pass(pass), .match_cnt(match_cnt),
        .fail_addr(fail_addr), .fail_data(fail_data)
    );

    bram_result_checker #(.DATA_W(DATA_W), .DEPTH(DEPTH1), .ADDR_W(ADDR_W), .ONE_SHOT(1)) dut1 (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .start(start), .op_sel(op_sel),
        .rd_en(rd_en1), .rd_addr(rd_addr1), .a_rdata(a_rdata1), .b_rdata(b_rdata1), .c_rdata(c_rdata1),
        .busy(busy1), .done(done1), .pass(pass1), .match_cnt(match_cnt1),
        .fail_addr(fail_addr1), .fail_data(fail_data1)
    );

    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) begin
        if (rd_en) begin
            a_rdata <= mem_a[rd_addr];
            b_rdata <= mem_b[rd_addr];
            c_rdata <= mem_c[rd_addr];
        end
        if (rd_en1) begin
            a_rdata1 <= mem_a[rd_addr1];
            b_rdata1 <= mem_b[rd_addr1];
            c_rdata1 <= mem_c[rd_addr1];
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: whole-run expectation computed from the memories at accept time.
    bit                m_chk_en = 1'b0;
    bit                m_active = 1'b0;
    bit                m_prev = 1'b0;
    bit                m_show = 1'b0;
    bit                m_accept;
    int                m_t = 0;
    logic              m_pass = 1'b0;
    logic [ADDR_W:0]   m_cnt = '0;
    logic [ADDR_W-1:0] m_fa = '0;
    logic [DATA_W-1:0] m_fd = '0;
    logic              e_pass;
    logic [ADDR_W:0]   e_cnt;
    logic [ADDR_W-1:0] e_fa;
    logic [DATA_W-1:0] e_fd, ex;
    bit                e_first;

    always @(posedge sys_clk) begin
        cyc = cyc + 1;
        if (!sys_rst) begin
            m_chk_en = 1'b1;
            m_active = 1'b0;
            m_prev   = 1'b0;
            m_t      = 0;
            m_pass   = 1'b0;
            m_cnt    = '0;
            m_fa     = '0;
            m_fd     = '0;
            m_show   = 1'b1;
        end else begin
            m_accept = !m_active && start && !m_prev;
            m_prev   = start;
            if (m_active) begin
                if (m_t == DEPTH + 1) begin
                    m_active = 1'b0;
                end else begin
                    m_t = m_t + 1;
                    if (m_t == DEPTH + 1) begin
                        m_pass = e_pass;
                        m_cnt  = e_cnt;
                        m_fa   = e_fa;
                        m_fd   = e_fd;
                        m_show = 1'b1;
                    end
                end
            end
            if (m_accept) begin
                e_cnt = '0;
                e_fa = '0;
                e_fd = '0;
                e_first = 1'b1;
                for (int i = 0; i < DEPTH; i++) begin
                    ex = op_sel ? mem_a[i] - mem_b[i] : mem_a[i] + mem_b[i];
                    if (mem_c[i] == ex) begin
                        e_cnt = e_cnt + 1'b1;
                    end else if (e_first) begin
                        e_first = 1'b0;
                        if (ERRLOG) begin
                            e_fa = ADDR_W'(i);
                            e_fd = mem_c[i];
                        end
                    end
                end
                e_pass   = (e_cnt == (ADDR_W + 1)'(DEPTH));
                m_active = 1'b1;
                m_t      = 0;
                m_pass   = 1'b0;
                m_cnt    = '0;
                m_fa     = '0;
                m_fd     = '0;
                m_show   = 1'b0;
            end
        end
    end

    always @(negedge sys_clk) begin
        if (m_chk_en) begin
            chk("busy", busy, m_active);
            chk("done", done, m_active && (m_t == DEPTH + 1));
            chk("rd_en", rd_en, m_active && (m_t < DEPTH));
            if (m_active && (m_t < DEPTH)) chk("rd_addr", rd_addr, m_t);
            chk("pass", pass, m_pass);
            if (m_show) begin
                chk("match_cnt", match_cnt, m_cnt);
                chk("fail_addr", fail_addr, m_fa);
                chk("fail_data", fail_data, m_fd);
            end
            if (rd_en1) chk("oneshot_rd_addr_range", rd_addr1 < DEPTH1, 1);
        end
        if (done) done_cnt++;
        if (done1) done1_cnt++;
        if (busy1) busy1_cycles++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    task automatic fill(input int mode);
        for (int i = 0; i < DEPTH; i++) begin
            if (mode == 0) begin
                mem_a[i] = i;
                mem_b[i] = i;
                mem_c[i] = 2 * i;
            end else begin
                mem_a[i] = 32'h0;
                mem_b[i] = 32'h1;
                mem_c[i] = 32'hFFFF_FFFF;
            end
        end
    endtask

    task automatic run(input bit flip_op, output int latency);
        int n0;
        latency = -1;
        start = 1'b1;
        n0 = cyc;
        tick(1);
        start = 1'b0;
        if (flip_op) op_sel = ~op_sel;
        for (int i = 0; i < 40; i++) begin
            @(negedge sys_clk);
            if (done) begin
                latency = cyc - n0;
                break;
            end
        end
        if (latency < 0) chk("done_timeout", 0, 1);
    endtask

    initial begin
        fill(0);
        tick(3);
        chk("reset_busy", busy, 0);
        chk("reset_rd_en", rd_en, 0);
        chk("reset_pass", pass, 0);
        chk("reset_match_cnt", match_cnt, 0);
        sys_rst = 1'b1;
        tick(2);

        run(1'b0, lat);
        chk("t1_latency", lat, 10);
        chk("t1_pass", pass, 1);
        chk("t1_match_cnt", match_cnt, 8);
        tick(2);
        chk("oneshot_first_done", done1_cnt, 1);
        chk("oneshot_first_pass", pass1, 1);

        mem_c[5] = 32'h0;
        b0 = busy1_cycles;
        run(1'b0, lat);
        chk("t2_latency", lat, 10);
        chk("t2_pass", pass, 0);
        chk("t2_match_cnt", match_cnt, 7);
        chk("t2_fail_addr", fail_addr, ERRLOG ? 5 : 0);
        chk("t2_fail_data", fail_data, 0);
        tick(3);
        chk("t2_pass_held", pass, 0);
        chk("oneshot_busy_stays_low", busy1_cycles - b0, 0);
        chk("oneshot_pass_held", pass1, 1);

        fill(1);
        op_sel = 1'b1;
        run(1'b1, lat);
        chk("t3_wrap_pass", pass, 1);
        chk("t3_wrap_match_cnt", match_cnt, 8);
        tick(2);

        fill(0);
        op_sel = 1'b0;
        d0 = done_cnt;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(3);
        start = 1'b1;
        tick(30);
        chk("t4_single_done", done_cnt - d0, 1);
        chk("t4_held_no_retrigger", busy, 0);
        start = 1'b0;
        tick(2);

        start = 1'b1;
        tick(1);
        start = 1'b0;
        guard = 0;
        do begin
            @(negedge sys_clk);
            guard++;
        end while (!(rd_en && rd_addr == 3'd3) && guard < 20);
        chk("t5_reached_addr3", guard < 20, 1);
        sys_rst = 1'b0;
        @(negedge sys_clk);
        chk("t5_busy", busy, 0);
        chk("t5_done", done, 0);
        chk("t5_rd_en", rd_en, 0);
        chk("t5_rd_addr", rd_addr, 0);
        chk("t5_pass", pass, 0);
        chk("t5_match_cnt", match_cnt, 0);
        chk("t5_fail_addr", fail_addr, 0);
        chk("t5_fail_data", fail_data, 0);
        sys_rst = 1'b1;
        d0 = done_cnt;
        tick(12);
        chk("t5_no_done", done_cnt - d0, 0);
        run(1'b0, lat);
        chk("t5_rerun_latency", lat, 10);
        chk("t5_rerun_pass", pass, 1);
        chk("t5_rerun_match_cnt", match_cnt, 8);
        tick(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/bram_result_checker.md
BRAM_RESULT_CHECKER -- requirements
Module: bram_result_checker

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, word width of operand and result memories.
REQ-002 The block SHALL have parameter DEPTH, default 8, number of words checked per run (1..65536).
REQ-003 The block SHALL have parameter ADDR_W, default 3, read-address width with 2**ADDR_W >= DEPTH.
REQ-004 The block SHALL have parameter ONE_SHOT, default 0; when 1 only the first accepted start after reset runs.
REQ-005 The block SHALL have port sys_clk, input, 1, sole clock with all logic on its rising edge.
REQ-006 The block SHALL have port sys_rst, input, 1, synchronous active-low reset.
REQ-007 The block SHALL have port start, input, 1, level from the accelerator done signal; a rising edge requests a check run.
REQ-008 The block SHALL have port op_sel, input, 1, expected-result operator: 0 = A+B, 1 = A-B; sampled on the accepted start.
REQ-009 The block SHALL have port rd_en, output, 1, read enable shared by the three memories.
REQ-010 The block SHALL have port rd_addr, output, ADDR_W, read address shared by the three memories.
REQ-011 The block SHALL have ports a_rdata, b_rdata and c_rdata, input, DATA_W each, read data valid exactly one cycle after rd_en.
REQ-012 The block SHALL have port busy, output, 1, high while a run is in progress.
REQ-013 The block SHALL have port done, output, 1, one-cycle pulse at the end of a run.
REQ-014 The block SHALL have port pass, output, 1, high when match_cnt equals DEPTH; valid from done until the next accepted start.
REQ-015 The block SHALL have port match_cnt, output, ADDR_W+1, count of matching words in the last run.
REQ-016 The block SHALL have ports fail_addr (ADDR_W) and fail_data (DATA_W), output, address and c_rdata of the first mismatch.

Function
REQ-017 The FSM SHALL have states IDLE, READ, DRAIN and DONE.
REQ-018 Start edge detection SHALL use a registered copy of start; an edge is accepted only in IDLE (and, when ONE_SHOT = 1, only if no run has completed since reset).
REQ-019 On an accepted edge the block SHALL clear match_cnt, pass and the fail registers, latch op_sel, and enter READ.
REQ-020 In READ the block SHALL assert rd_en with rd_addr = 0,1,..,DEPTH-1 on consecutive cycles and then enter DRAIN.
REQ-021 Each cycle after a read the block SHALL compare c_rdata with (a_rdata op b_rdata) truncated modulo 2**DATA_W; on equality it increments match_cnt.
REQ-022 In DRAIN the block SHALL perform the final comparison, then enter DONE.
REQ-023 In DONE the block SHALL pulse done for one cycle, set pass, and return to IDLE; done SHALL rise DEPTH+2 cycles after the cycle that accepts start.
REQ-024 busy SHALL be high in READ, DRAIN and DONE, and low in IDLE.
REQ-025 A start edge or op_sel change during busy SHALL be ignored, with no queuing.
REQ-026 rd_addr SHALL not wrap; for DEPTH < 2**ADDR_W the addresses DEPTH..2**ADDR_W-1 SHALL never be issued.
REQ-027 When start is held high it SHALL not retrigger; a new run requires a low level followed by a high level.

Reset
REQ-028 When sys_rst = 0 at a clock edge, the block SHALL force state IDLE, with rd_en, rd_addr, busy, done, pass, match_cnt, fail_addr, fail_data, the start history and the one-shot flag all 0.
REQ-029 Reset mid-run SHALL abandon the run with no done pulse, and the first accepted edge after reset release SHALL start a fresh run.

Configuration
REQ-030 With macro CHECKER_ERRLOG_EN defined, fail_addr and fail_data SHALL capture the first mismatch of a run and hold it until the next accepted start.
REQ-031 Without CHECKER_ERRLOG_EN, fail_addr and fail_data SHALL be constant 0, no capture registers SHALL exist, and all other behaviour SHALL be unchanged.

Verification
REQ-032 The bench SHALL cover: DEPTH = 8, A[i] = i, B[i] = i, C[i] = 2i, op_sel = 0, start edge -> done at +10 cycles, pass = 1, match_cnt = 8.
REQ-033 The bench SHALL cover: same data with C[5] = 0 -> pass = 0, match_cnt = 7, fail_addr = 5, fail_data = 0 (with CHECKER_ERRLOG_EN).
REQ-034 The bench SHALL cover: op_sel = 1, A[i] = 0, B[i] = 1, C[i] = 0xFFFFFFFF -> pass = 1, confirming wrap-around arithmetic.
REQ-035 The bench SHALL cover: a second start edge while busy -> exactly one done pulse; with ONE_SHOT = 1, a later edge -> busy stays 0.
REQ-036 The bench SHALL cover: sys_rst = 0 at rd_addr = 3 -> all outputs 0 the next cycle, no done; a new edge then gives a full 8-word run.
